ddr_app_arbiter: RTL

//  Shares the single DDR3 IP user (app_*) command/data port between two requesters (p0, p1).

---
 rtl/ddr_arb_pkg.sv | 17 +
 rtl/ddr_arb_tag_fifo.sv | 61 ++++++
 rtl/ddr_app_arbiter.sv | 175 +++++++++++++++++
 3 files changed

// File: rtl/ddr_arb_pkg.sv
// Shared types and app command encodings for the DDR3 app-port arbiter.
// Latency: n/a (types only).
// Backpressure: n/a (types only).
package ddr_arb_pkg;

    localparam logic [2:0] CMD_WR = 3'b000;
    localparam logic [2:0] CMD_RD = 3'b001;

    typedef enum logic {
        IDLE  = 1'b0,
        ISSUE = 1'b1
    } arb_state_t;

    // Requester index: 0 = p0, 1 = p1.
    typedef logic port_id_t;

endpackage

// File: rtl/ddr_arb_tag_fifo.sv
// In-order FIFO of requester ids for reads that the DDR3 IP has accepted.
// Latency: head valid the cycle after push; pop takes effect at the clock edge.
// Backpressure: push ignored when full (unless popping); pop on empty is ignored.
module ddr_arb_tag_fifo
    import ddr_arb_pkg::*;
#(
    parameter int DEPTH = 16
) (
    input  logic     clk,
    input  logic     rst,
    input  logic     push,
    input  port_id_t push_id,
    input  logic     pop,
    output port_id_t head,
    output logic     full,
    output logic     empty
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] FULL_CNT = (AW + 1)'(DEPTH);

    port_id_t        mem [DEPTH];
    logic [AW-1:0]   wr_ptr;
    logic [AW-1:0]   rd_ptr;
    logic [AW:0]     count;
    logic            do_push;
    logic            do_pop;

    assign empty   = (count == '0);
    assign full    = (count == FULL_CNT);
    assign do_pop  = pop & ~empty;
    assign do_push = push & (~full | do_pop);
    assign head    = mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr] <= push_id;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            case ({do_push, do_pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/ddr_app_arbiter.sv
// Round-robin share of the DDR3 app port between p0/p1; read data routed by tag FIFO. Optional DDR_ARB_PERF_EN adds counters.
// Latency: ready at cycle N -> app_en at N+1; app_rd_data_valid at N -> pN_rd_valid at N+1; >=2 cycles per command.
// Backpressure: app command held until app_rdy (and wr_data_rdy for writes); reads not granted while tag FIFO is full.
module ddr_app_arbiter
    import ddr_arb_pkg::*;
#(
    parameter int ADDR_WIDTH     = 28,
    parameter int APP_DATA_WIDTH = 256,
    parameter int APP_MASK_WIDTH = 32,
    parameter int RD_TAG_DEPTH   = 16
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      init_calib_complete,
    input  logic                      p0_req_valid,
    output logic                      p0_req_ready,
    input  logic                      p0_req_rd,
    input  logic [ADDR_WIDTH-1:0]     p0_req_addr,
    input  logic [APP_DATA_WIDTH-1:0] p0_req_wdata,
    output logic                      p0_rd_valid,
    input  logic                      p1_req_valid,
    output logic                      p1_req_ready,
    input  logic                      p1_req_rd,
    input  logic [ADDR_WIDTH-1:0]     p1_req_addr,
    input  logic [APP_DATA_WIDTH-1:0] p1_req_wdata,
    output logic                      p1_rd_valid,
    output logic [APP_DATA_WIDTH-1:0] rd_data,
    output logic                      err_unexp_rd,
    output logic                      app_en,
    output logic [2:0]                app_cmd,
    output logic [ADDR_WIDTH-1:0]     app_addr,
    output logic [APP_DATA_WIDTH-1:0] app_wdf_data,
    output logic                      app_wdf_wren,
    output logic                      app_wdf_end,
    output logic [APP_MASK_WIDTH-1:0] app_wdf_mask,
    input  logic                      app_rdy,
    input  logic                      wr_data_rdy,
    input  logic                      app_rd_data_valid,
    input  logic [APP_DATA_WIDTH-1:0] app_rd_data
`ifdef DDR_ARB_PERF_EN
    ,
    output logic [31:0]               p0_cmd_cnt,
    output logic [31:0]               p1_cmd_cnt,
    output logic [31:0]               stall_cnt
`endif
);

    arb_state_t                state;
    arb_state_t                state_nxt;
    port_id_t                  rr_last;
    port_id_t                  cur_port;
    logic                      cur_rd;
    logic [ADDR_WIDTH-1:0]     cur_addr;
    logic [APP_DATA_WIDTH-1:0] cur_wdata;

    logic                      elig0;
    logic                      elig1;
    logic                      grant_vld;
    port_id_t                  grant_id;
    logic                      accept;

    logic                      tag_full;
    logic                      tag_empty;
    port_id_t                  tag_head;

    assign elig0 = p0_req_valid & init_calib_complete & (~p0_req_rd | ~tag_full);
    assign elig1 = p1_req_valid & init_calib_complete & (~p1_req_rd | ~tag_full);
    assign accept = (state == ISSUE) & app_rdy & (cur_rd | wr_data_rdy);

    always_comb begin
        state_nxt = state;
        grant_vld = 1'b0;
        grant_id  = rr_last;
        case (state)
            IDLE: begin
                if (~rst & (elig0 | elig1)) begin
                    grant_vld = 1'b1;
                    // On contention the port granted last time loses.
                    grant_id  = (elig0 & elig1) ? ~rr_last : elig1;
                    state_nxt = ISSUE;
                end
            end
            ISSUE: begin
                if (accept) begin
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    assign p0_req_ready = grant_vld & (grant_id == 1'b0);
    assign p1_req_ready = grant_vld & (grant_id == 1'b1);

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            rr_last   <= 1'b1;
            cur_port  <= 1'b0;
            cur_rd    <= 1'b0;
            cur_addr  <= '0;
            cur_wdata <= '0;
        end else begin
            state <= state_nxt;
            if (grant_vld) begin
                rr_last   <= grant_id;
                cur_port  <= grant_id;
                cur_rd    <= grant_id ? p1_req_rd    : p0_req_rd;
                cur_addr  <= grant_id ? p1_req_addr  : p0_req_addr;
                cur_wdata <= grant_id ? p1_req_wdata : p0_req_wdata;
            end
        end
    end

    assign app_en       = (state == ISSUE);
    assign app_cmd      = (app_en & cur_rd) ? CMD_RD : CMD_WR;
    assign app_addr     = cur_addr;
    assign app_wdf_data = cur_wdata;
    assign app_wdf_wren = app_en & ~cur_rd;
    assign app_wdf_end  = app_en & ~cur_rd;
    assign app_wdf_mask = '0;

    ddr_arb_tag_fifo #(
        .DEPTH   (RD_TAG_DEPTH)
    ) u_tag_fifo (
        .clk     (clk),
        .rst     (rst),
        .push    (accept & cur_rd),
        .push_id (cur_port),
        .pop     (app_rd_data_valid),
        .head    (tag_head),
        .full    (tag_full),
        .empty   (tag_empty)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            p0_rd_valid  <= 1'b0;
            p1_rd_valid  <= 1'b0;
            rd_data      <= '0;
            err_unexp_rd <= 1'b0;
        end else begin
            p0_rd_valid <= app_rd_data_valid & ~tag_empty & (tag_head == 1'b0);
            p1_rd_valid <= app_rd_data_valid & ~tag_empty & (tag_head == 1'b1);
            if (app_rd_data_valid & ~tag_empty) begin
                rd_data <= app_rd_data;
            end
            // Data with no outstanding read is dropped and flagged until reset.
            if (app_rd_data_valid & tag_empty) begin
                err_unexp_rd <= 1'b1;
            end
        end
    end

`ifdef DDR_ARB_PERF_EN
    always_ff @(posedge clk) begin
        if (rst) begin
            p0_cmd_cnt <= '0;
            p1_cmd_cnt <= '0;
            stall_cnt  <= '0;
        end else begin
            if (accept & (cur_port == 1'b0)) begin
                p0_cmd_cnt <= p0_cmd_cnt + 32'd1;
            end
            if (accept & (cur_port == 1'b1)) begin
                p1_cmd_cnt <= p1_cmd_cnt + 32'd1;
            end
            if ((state == ISSUE) & ~accept) begin
                stall_cnt <= stall_cnt + 32'd1;
            end
        end
    end
`endif

endmodule
